pwm_dac: RTL and testbench

- Downstream stage of the function generator's waveform sources (triangle, sawtooth, square).
- Consumes an unsigned sample stream and converts it to a single-bit PWM output that feeds the board RC filter / DAC pin.
- Double-buffers each sample so that duty changes take effect only at PWM period boundaries.
- Requests the next sample from the upstream generator once per period.

---
 rtl/pwm_pkg.sv | 16 +
 rtl/pwm_prescaler.sv | 32 +++
 rtl/pwm_dac.sv | 121 ++++++++++++
 tb/tb_pwm_dac.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, counter-direction type and MAX derivation for the PWM DAC.
package pwm_pkg;

   localparam int unsigned PWM_DEF_WIDTH    = 8;
   localparam int unsigned PWM_DEF_PRESCALE = 1;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pwm_dir_e;

   function automatic int unsigned pwm_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock-enable divider: emits one tick every PRESCALE enabled clk cycles.
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int unsigned PRESCALE = PWM_DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_q, presc_d;

   always_comb begin
      presc_d = presc_q;
      if (en) begin
         presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) presc_q <= '0;
      else      presc_q <= presc_d;
   end

   assign tick = en && (presc_q == LAST);

endmodule

// File: rtl/pwm_dac.sv
// Double-buffered sample-to-PWM converter with a once-per-period sample request.
// PWM_CENTER_ALIGNED_EN selects an up/down (center-aligned) counter instead of a sawtooth.
module pwm_dac
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH    = PWM_DEF_WIDTH,
   parameter int unsigned PRESCALE = PWM_DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   output logic             sample_ready,
   output logic             pwm_out,
   output logic             period_start,
   output logic [WIDTH-1:0] duty_q
);

   localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(pwm_max(WIDTH) - 1);

   logic             tick;
   logic             boundary;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] duty_cur_q, duty_cur_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             full_q, full_d;
   logic             pwm_q, pwm_d;
   logic             pstart_q;

   pwm_prescaler #(.PRESCALE(PRESCALE)) u_presc (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

`ifdef PWM_CENTER_ALIGNED_EN
   pwm_dir_e dir_q, dir_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) dir_q <= DIR_UP;
      else      dir_q <= dir_d;
   end

   // Boundary is the DOWN->UP turn, so a period is 0..MAX..1.
   always_comb begin
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      boundary = 1'b0;
      if (tick) begin
         case (dir_q)
            DIR_UP: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == MAX_M1) dir_d = DIR_DOWN;
            end
            DIR_DOWN: begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == WIDTH'(1)) begin
                  dir_d    = DIR_UP;
                  boundary = 1'b1;
               end
            end
            default: dir_d = DIR_UP;
         endcase
      end
   end
`else
   always_comb begin
      cnt_d    = cnt_q;
      boundary = 1'b0;
      if (tick) begin
         if (cnt_q == MAX_M1) begin
            cnt_d    = '0;
            boundary = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end
`endif

   // A full shadow blocks new transfers, so a boundary load and a transfer never collide.
   always_comb begin
      duty_cur_d = duty_cur_q;
      shadow_d   = shadow_q;
      full_d     = full_q;
      if (boundary && full_q) begin
         duty_cur_d = shadow_q;
         full_d     = 1'b0;
      end else if (sample_valid && !full_q) begin
         shadow_d = sample_in;
         full_d   = 1'b1;
      end
      pwm_d = en && (cnt_q < duty_cur_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q      <= '0;
         duty_cur_q <= '0;
         shadow_q   <= '0;
         full_q     <= 1'b0;
         pwm_q      <= 1'b0;
         pstart_q   <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         duty_cur_q <= duty_cur_d;
         shadow_q   <= shadow_d;
         full_q     <= full_d;
         pwm_q      <= pwm_d;
         pstart_q   <= boundary;
      end
   end

   assign sample_ready = !full_q;
   assign pwm_out      = pwm_q;
   assign period_start = pstart_q;
   assign duty_q       = duty_cur_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: an 8-bit PRESCALE=1 instance and an 8-bit PRESCALE=4 instance.
module tb_pwm_dac;

   localparam int MAXV = 255;

   logic       clk;
   logic       rst, en, sample_valid;
   logic [7:0] sample_in;
   logic       sample_ready, pwm_out, period_start;
   logic [7:0] duty_q;

   logic       rst4, en4, sample_valid4;
   logic [7:0] sample_in4;
   logic       sample_ready4, pwm_out4, period_start4;
   logic [7:0] duty_q4;

   int checks   = 0;
   int failures = 0;

   pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .duty_q       (duty_q)
   );

   pwm_dac #(.WIDTH(8), .PRESCALE(4)) dut4 (
      .clk          (clk),
      .rst          (rst4),
      .en           (en4),
      .sample_in    (sample_in4),
      .sample_valid (sample_valid4),
      .sample_ready (sample_ready4),
      .pwm_out      (pwm_out4),
      .period_start (period_start4),
      .duty_q       (duty_q4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Steps negedges until the selected instance shows period_start; n = negedges consumed.
   task automatic wait_ps(input bit sel4, input int limit, output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < limit) begin
         @(negedge clk);
         n++;
         if ((sel4 ? period_start4 : period_start) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      int n;
      bit ok;
      @(negedge clk);
      rst = 1'b1; en = 1'b1; sample_in = 8'd128; sample_valid = 1'b1;
      checks++;
      if (sample_ready !== 1'b1 || duty_q !== 8'd0 || pwm_out !== 1'b0 || period_start !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: ready=%b duty=%0d pwm=%b ps=%b required 1/0/0/0",
                  sample_ready, duty_q, pwm_out, period_start);
      end
      @(posedge clk); #1 sample_valid = 1'b0;
      wait_ps(1'b0, 600, n, ok);
      checks++;
      if (!ok || n != MAXV) begin
         failures++;
         $display("FAIL first_boundary: got %0d cycles (seen=%b) required %0d", n, ok, MAXV);
      end
      checks++;
      if (duty_q !== 8'd128) begin
         failures++;
         $display("FAIL first_duty: got %0d required 128", duty_q);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (pwm_out !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_pwm: got %b required 1", pwm_out);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (pwm_out !== 1'b0 || duty_q !== 8'd0 || period_start !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: pwm=%b duty=%0d ps=%b required 0/0/0", pwm_out, duty_q, period_start);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (sample_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_reset: got %b required 1", sample_ready);
      end
      wait_ps(1'b0, 600, n, ok);
      checks++;
      if (!ok || n != MAXV || duty_q !== 8'd0) begin
         failures++;
         $display("FAIL boundary_after_reset: got %0d cycles duty=%0d required %0d cycles duty=0",
                  n, duty_q, MAXV);
      end
   endtask

   task automatic test_duty();
      int vals[7];
      vals[0] = 64; vals[1] = 0; vals[2] = 255;
      for (int i = 3; i < 7; i++) vals[i] = int'($urandom_range(1, 254));
      foreach (vals[i]) begin
         int d, n, nper;
         bit ok;
         d = vals[i];
         sample_in = 8'(d); sample_valid = 1'b1;
         n = 0;
         while (sample_ready !== 1'b1 && n < 600) begin @(negedge clk); n++; end
         @(posedge clk); #1 sample_valid = 1'b0;
         wait_ps(1'b0, 600, n, ok);
         checks++;
         if (!ok || duty_q !== 8'(d)) begin
            failures++;
            $display("FAIL duty_apply[%0d]: duty=%0d seen=%b required %0d", d, duty_q, ok, d);
         end
         nper = (d == 64) ? 2 : 1;
         for (int p = 0; p < nper; p++) begin
            int highs, bad, ps_cnt, ps_idx;
            highs = 0; bad = 0; ps_cnt = 0; ps_idx = -1;
            for (int k = 0; k < MAXV; k++) begin
               @(negedge clk);
               if (pwm_out !== 1'(k < d)) bad++;
               if (pwm_out === 1'b1) highs++;
               if (period_start === 1'b1) begin ps_cnt++; ps_idx = k; end
            end
            checks++;
            if (bad != 0 || highs != d) begin
               failures++;
               $display("FAIL duty_wave[%0d] period %0d: highs=%0d misplaced=%0d required highs=%0d misplaced=0",
                        d, p, highs, bad, d);
            end
            checks++;
            if (ps_cnt != 1 || ps_idx != MAXV - 1) begin
               failures++;
               $display("FAIL duty_period[%0d]: period_start count=%0d at %0d required 1 at %0d",
                        d, ps_cnt, ps_idx, MAXV - 1);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bit ok;
      logic [7:0] prev;
      prev = duty_q;
      sample_in = 8'd10; sample_valid = 1'b1;
      @(posedge clk); #1 sample_in = 8'd20;
      @(negedge clk);
      checks++;
      if (sample_ready !== 1'b0 || duty_q !== prev) begin
         failures++;
         $display("FAIL b2b_hold: ready=%b duty=%0d required 0/%0d", sample_ready, duty_q, prev);
      end
      wait_ps(1'b0, 600, n, ok);
      checks++;
      if (!ok || duty_q !== 8'd10 || sample_ready !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first: duty=%0d ready=%b seen=%b required 10/1/1", duty_q, sample_ready, ok);
      end
      @(posedge clk); #1 sample_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (sample_ready !== 1'b0 || duty_q !== 8'd10) begin
         failures++;
         $display("FAIL b2b_second_accept: ready=%b duty=%0d required 0/10", sample_ready, duty_q);
      end
      wait_ps(1'b0, 600, n, ok);
      checks++;
      if (!ok || n + 1 != MAXV || duty_q !== 8'd20) begin
         failures++;
         $display("FAIL b2b_second: duty=%0d cycles=%0d required 20/%0d", duty_q, n + 1, MAXV);
      end
   endtask

   task automatic test_boundary_transfer();
      int n;
      bit ok;
      logic [7:0] x, prev;
      prev = duty_q;
      x = 8'($urandom_range(21, 250));
      repeat (MAXV - 1) @(negedge clk);
      sample_in = x; sample_valid = 1'b1;
      @(posedge clk); #1 sample_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (period_start !== 1'b1 || duty_q !== prev || sample_ready !== 1'b0) begin
         failures++;
         $display("FAIL coincident_boundary: ps=%b duty=%0d ready=%b required 1/%0d/0",
                  period_start, duty_q, sample_ready, prev);
      end
      wait_ps(1'b0, 600, n, ok);
      checks++;
      if (!ok || n != MAXV || duty_q !== x) begin
         failures++;
         $display("FAIL coincident_next: duty=%0d cycles=%0d required %0d/%0d", duty_q, n, x, MAXV);
      end
   endtask

   task automatic run_period4(input bit drop, output int len, output int highs, output int zbad);
      int off;
      bit done;
      len = 0; highs = 0; zbad = 0; off = 0; done = 1'b0;
      while (len < 1300 && !done) begin
         @(negedge clk);
         len++;
         if (pwm_out4 === 1'b1) highs++;
         if (period_start4 === 1'b1) done = 1'b1;
         if (off > 0) begin
            if (pwm_out4 !== 1'b0 || period_start4 !== 1'b0) zbad++;
            off--;
            if (off == 0) en4 = 1'b1;
         end else if (drop && len == 100) begin
            en4 = 1'b0;
            off = 37;
         end
      end
   endtask

   task automatic test_prescale_en();
      int n, len, highs, zbad, d4;
      bit ok;
      d4 = int'($urandom_range(100, 200));
      @(negedge clk);
      rst4 = 1'b1; en4 = 1'b1; sample_in4 = 8'(d4); sample_valid4 = 1'b1;
      @(posedge clk); #1 sample_valid4 = 1'b0;
      wait_ps(1'b1, 1200, n, ok);
      checks++;
      if (!ok || n != 4 * MAXV || duty_q4 !== 8'(d4)) begin
         failures++;
         $display("FAIL presc_first: cycles=%0d duty=%0d required %0d/%0d", n, duty_q4, 4 * MAXV, d4);
      end
      run_period4(1'b0, len, highs, zbad);
      checks++;
      if (len != 4 * MAXV || highs != 4 * d4) begin
         failures++;
         $display("FAIL presc_period: len=%0d highs=%0d required %0d/%0d", len, highs, 4 * MAXV, 4 * d4);
      end
      run_period4(1'b1, len, highs, zbad);
      checks++;
      if (len != 4 * MAXV + 37 || highs != 4 * d4) begin
         failures++;
         $display("FAIL en_stretch: len=%0d highs=%0d required %0d/%0d", len, highs, 4 * MAXV + 37, 4 * d4);
      end
      checks++;
      if (zbad != 0) begin
         failures++;
         $display("FAIL en_forces_zero: %0d cycles with output active, required 0", zbad);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; sample_in = '0; sample_valid = 1'b0;
      rst4 = 1'b0; en4 = 1'b0; sample_in4 = '0; sample_valid4 = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      test_duty();
      test_back_to_back();
      test_boundary_transfer();
      test_prescale_en();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
